// File: rtl/count_seq_checker.sv
// Shadow-model checker for the even/odd stride counter: compares count_in against a registered model.
// Optional mismatch log FIFO enabled by defining CSC_ERR_LOG_EN.
module count_seq_checker #(
  parameter int WIDTH      = 4,
  parameter int STEP       = 2,
  parameter int ERR_CNT_W  = 8,
  parameter int MAX_FAULTS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 chk_en,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     expected,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 wrap,
  output logic                 locked,
  output logic                 fault
`ifdef CSC_ERR_LOG_EN
  ,
  input  logic                 log_pop,
  output logic [2*WIDTH-1:0]   log_data,
  output logic                 log_vld,
  output logic                 log_ovf
`endif
);

  typedef enum logic [1:0] {IDLE, CHECK, SUSPECT, FAULT} state_t;

  localparam logic [WIDTH:0]     STEP_V  = (WIDTH+1)'(STEP);
  localparam logic [3:0]         MAXF    = 4'(MAX_FAULTS);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     exp_reg, exp_next;
  logic                 wrap_reg, wrap_next;
  logic                 err_reg, err_next;
  logic                 sticky_reg, sticky_next;
  logic [ERR_CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]           fcnt_reg, fcnt_next;

  logic                 adv;
  logic                 active;
  logic                 mism;
  logic [WIDTH-1:0]     base;
  logic [WIDTH:0]       sum;
  logic [ERR_CNT_W-1:0] cnt_base;
  logic [3:0]           fcnt_base;

  always_comb begin
    adv       = (mode == data_in[0]);
    active    = chk_en && (state_reg == CHECK || state_reg == SUSPECT);
    mism      = active && (count_in != exp_reg);
    // On a counted mismatch, and continuously in FAULT, the model follows the counter.
    base      = (mism || state_reg == FAULT) ? count_in : exp_reg;
    sum       = {1'b0, base} + STEP_V;
    exp_next  = base;
    wrap_next = 1'b0;
    if (adv && load) begin
      exp_next = data_in;
    end else if (adv) begin
      exp_next  = sum[WIDTH-1:0];
      wrap_next = sum[WIDTH];
    end

    cnt_base    = clr_err ? '0 : cnt_reg;
    fcnt_base   = clr_err ? 4'd0 : fcnt_reg;
    cnt_next    = cnt_base;
    fcnt_next   = fcnt_base;
    sticky_next = (clr_err ? 1'b0 : sticky_reg) | mism;
    err_next    = mism;
    if (mism) begin
      if (cnt_base != ERR_MAX) cnt_next = cnt_base + 1'b1;
      if (fcnt_base != 4'hF)   fcnt_next = fcnt_base + 4'd1;
    end else if (active) begin
      fcnt_next = 4'd0;
    end

    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = CHECK;
      CHECK, SUSPECT: begin
        if (mism)        state_next = (fcnt_next >= MAXF) ? FAULT : SUSPECT;
        else if (active) state_next = CHECK;
      end
      FAULT:   if (clr_err) state_next = CHECK;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      exp_reg    <= '0;
      wrap_reg   <= 1'b0;
      err_reg    <= 1'b0;
      sticky_reg <= 1'b0;
      cnt_reg    <= '0;
      fcnt_reg   <= 4'd0;
    end else begin
      state_reg  <= state_next;
      exp_reg    <= exp_next;
      wrap_reg   <= wrap_next;
      err_reg    <= err_next;
      sticky_reg <= sticky_next;
      cnt_reg    <= cnt_next;
      fcnt_reg   <= fcnt_next;
    end
  end

  assign expected   = exp_reg;
  assign err        = err_reg;
  assign err_sticky = sticky_reg;
  assign err_cnt    = cnt_reg;
  assign wrap       = wrap_reg;
  assign locked     = (state_reg == CHECK);
  assign fault      = (state_reg == FAULT);

`ifdef CSC_ERR_LOG_EN
  logic [2*WIDTH-1:0] log_mem [0:3];
  logic [1:0]         rd_ptr_reg, wr_ptr_reg;
  logic [2:0]         log_cnt_reg;
  logic               ovf_reg;
  logic               pop_ok, do_push;
  logic [1:0]         wr_idx;

  always_comb begin
    pop_ok  = log_pop && (log_cnt_reg != 3'd0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    do_push = mism && (clr_err || log_cnt_reg != 3'd4 || pop_ok);
    wr_idx  = clr_err ? 2'd0 : wr_ptr_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) log_mem[wr_idx] <= {exp_reg, count_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg  <= 2'd0;
      wr_ptr_reg  <= 2'd0;
      log_cnt_reg <= 3'd0;
      ovf_reg     <= 1'b0;
    end else if (clr_err) begin
      rd_ptr_reg  <= 2'd0;
      wr_ptr_reg  <= do_push ? 2'd1 : 2'd0;
      log_cnt_reg <= do_push ? 3'd1 : 3'd0;
      ovf_reg     <= 1'b0;
    end else begin
      if (mism && !do_push) ovf_reg <= 1'b1;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      log_cnt_reg <= log_cnt_reg + 3'(do_push) - 3'(pop_ok);
    end
  end

  assign log_data = log_mem[rd_ptr_reg];
  assign log_vld  = (log_cnt_reg != 3'd0);
  assign log_ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed self-checking bench for count_seq_checker (default build, MAX_FAULTS=3).
module tb_count_seq_checker;
  logic       clk = 1'b0;
  logic       rst, load, mode, chk_en, clr_err;
  logic [3:0] data_in, count_in;
  logic [3:0] expected;
  logic       err, err_sticky, wrap, locked, fault;
  logic [7:0] err_cnt;

  int compared = 0;
  int mismatched = 0;

  count_seq_checker #(.WIDTH(4), .STEP(2), .ERR_CNT_W(8), .MAX_FAULTS(3)) dut (
    .clk(clk), .rst(rst), .load(load), .mode(mode), .data_in(data_in),
    .count_in(count_in), .chk_en(chk_en), .clr_err(clr_err),
    .expected(expected), .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt),
    .wrap(wrap), .locked(locked), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e, input logic er,
                           input logic st, input logic [7:0] c, input logic w,
                           input logic lk, input logic f);
    check({tag, ".expected"}, 32'(expected), 32'(e));
    check({tag, ".err"}, 32'(err), 32'(er));
    check({tag, ".err_sticky"}, 32'(err_sticky), 32'(st));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(c));
    check({tag, ".wrap"}, 32'(wrap), 32'(w));
    check({tag, ".locked"}, 32'(locked), 32'(lk));
    check({tag, ".fault"}, 32'(fault), 32'(f));
    $display("step %s: expected=%0d err=%0b sticky=%0b cnt=%0d wrap=%0b locked=%0b fault=%0b",
             tag, expected, err, err_sticky, err_cnt, wrap, locked, fault);
  endtask

  initial begin
    logic [3:0] cin;
    rst = 1'b1; load = 1'b0; mode = 1'b0; data_in = 4'd0;
    count_in = 4'd0; chk_en = 1'b1; clr_err = 1'b0;
    tick(); tick();
    check_all("reset", 4'd0, 0, 0, 8'd0, 0, 0, 0);

    // Load 4, then stride by 2 with a correct counter on count_in.
    rst = 1'b0; mode = 1'b0; data_in = 4'd4; load = 1'b1; count_in = 4'd0;
    tick();
    check_all("load4", 4'd4, 0, 0, 8'd0, 0, 1, 0);
    load = 1'b0;
    cin = 4'd4;
    for (int i = 0; i < 7; i++) begin
      count_in = cin;
      tick();
      cin = cin + 4'd2;
      check_all($sformatf("stride%0d", i), cin, 0, 0, 8'd0, (cin == 4'd0), 1, 0);
    end

    // Parity mismatch holds the model.
    mode = 1'b1; data_in = 4'd6; count_in = 4'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("hold%0d", i), 4'd2, 0, 0, 8'd0, 0, 1, 0);
    end

    // Bring model to 6.
    mode = 1'b0; data_in = 4'd4; load = 1'b1; count_in = 4'd2;
    tick();
    load = 1'b0; count_in = 4'd4;
    tick();
    check_all("to6", 4'd6, 0, 0, 8'd0, 0, 1, 0);

    // Single corruption with odd advance: resync 7 -> 9.
    mode = 1'b1; data_in = 4'd1; count_in = 4'd7;
    tick();
    check_all("corrupt", 4'd9, 1, 1, 8'd1, 0, 0, 0);
    count_in = 4'd9;
    tick();
    check_all("recover", 4'd11, 0, 1, 8'd1, 0, 1, 0);

    // Clear, then three consecutive mismatches into FAULT.
    mode = 1'b1; data_in = 4'd6; clr_err = 1'b1; count_in = 4'd11;
    tick();
    check_all("clr1", 4'd11, 0, 0, 8'd0, 0, 1, 0);
    clr_err = 1'b0;
    count_in = 4'd0;  tick();
    check_all("mis1", 4'd0, 1, 1, 8'd1, 0, 0, 0);
    count_in = 4'd5;  tick();
    check_all("mis2", 4'd5, 1, 1, 8'd2, 0, 0, 0);
    count_in = 4'd9;  tick();
    check_all("mis3", 4'd9, 1, 1, 8'd3, 0, 0, 1);
    count_in = 4'd3;  tick();
    check_all("mis4", 4'd3, 0, 1, 8'd3, 0, 0, 1);
    clr_err = 1'b1;   tick();
    check_all("clr2", 4'd3, 0, 0, 8'd0, 0, 1, 0);
    clr_err = 1'b0;

    // Five isolated mismatches, each followed by a match.
    for (int j = 0; j < 5; j++) begin
      count_in = 4'(8 + j); tick();
      count_in = 4'(8 + j); tick();
    end
    check_all("five", 4'd12, 0, 1, 8'd5, 0, 1, 0);

    // Mismatch coincident with clr_err.
    clr_err = 1'b1; count_in = 4'd0;
    tick();
    check_all("clrmis", 4'd0, 1, 1, 8'd1, 0, 0, 0);
    clr_err = 1'b0;

    // Reset in SUSPECT.
    rst = 1'b1; count_in = 4'd5;
    tick();
    check_all("rstmid", 4'd0, 0, 0, 8'd0, 0, 0, 0);

    // chk_en=0: model runs, no compare.
    rst = 1'b0; mode = 1'b0; data_in = 4'd4; count_in = 4'd0;
    tick();
    check_all("run", 4'd2, 0, 0, 8'd0, 0, 1, 0);
    chk_en = 1'b0; count_in = 4'd9;
    tick();
    check_all("noen", 4'd4, 0, 0, 8'd0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
